piso_shift_tx: RTL and testbench

- Parallel-in / serial-out transmitter in the 74x165 style, extended with a valid/ready load handshake, a programmable bit period and an inter-word gap.
- Takes a WIDTH-bit word from the core side and shifts it out MSB first on QH, with complementary output QH_N.
- FRAME and DONE mark word boundaries so a downstream serial-in part (74x164-style) can frame data.
- Targets the same XC2 CPLD designs as the existing 74-series gate blocks.

---
 rtl/piso_pkg.sv | 28 ++
 rtl/bit_tick_gen.sv | 39 +++
 rtl/piso_shift_tx.sv | 132 +++++++++++++
 tb/tb_piso_shift_tx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types, constants and helpers for the PISO serial transmitter.
// States are plain logic constants so older flows read them unchanged.
package piso_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  localparam logic QH_RST    = 1'b0;
  localparam logic FRAME_RST = 1'b0;
  localparam logic DONE_RST  = 1'b0;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// DIV-cycle period counter; TICK marks the last cycle of each period.
// Held at zero while RESTART is high so a period starts cleanly.
module bit_tick_gen
  import piso_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic RESTART,
  output logic TICK
);

  localparam int CW = (clog2(DIV) > 0) ? clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign TICK = (cnt_q == CNT_LAST);

  // Count up, wrapping after the last cycle of a period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (RESTART || TICK) begin
      cnt_d = '0;
    end
  end

  // Period counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// 74x165-style parallel-in/serial-out transmitter, MSB first,
// with valid/ready load, programmable bit period and inter-word gap.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int GAP   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  input  logic             SER_IN,
  output logic             QH,
  output logic             QH_N,
  output logic             FRAME,
  output logic             DONE
);

  localparam int BW = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
  localparam int GW =
    (clog2(GAP * DIV + 1) > 0) ? clog2(GAP * DIV + 1) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             tick;
  logic             last_bit;
  logic             word_end;

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .RESTART(state_q == ST_IDLE),
    .TICK   (tick)
  );

  assign last_bit = (bit_q == BIT_LAST);
  assign word_end = (state_q == ST_SHIFT) && tick && last_bit;

  assign D_READY = (state_q == ST_IDLE) ||
                   (word_end && (GAP == 0));
  assign QH    = shreg_q[WIDTH-1];
  assign QH_N  = ~shreg_q[WIDTH-1];
  assign FRAME = frame_q;
  assign DONE  = done_q;

  // Next-state: load, shift per bit period, gap timing.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (D_VALID) begin
          shreg_d = D;
          bit_d   = '0;
          frame_d = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          shreg_d = {shreg_q[WIDTH-2:0], SER_IN};
          bit_d   = bit_q + 1'b1;
          if (last_bit) begin
            done_d = 1'b1;
            bit_d  = '0;
            gap_d  = '0;
            if (GAP == 0 && D_VALID) begin
              shreg_d = D;
              frame_d = 1'b1;
            end else if (GAP == 0) begin
              frame_d = 1'b0;
              state_d = ST_IDLE;
            end else begin
              frame_d = 1'b0;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_END) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        frame_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{QH_RST}};
      bit_q   <= '0;
      gap_q   <= '0;
      frame_q <= FRAME_RST;
      done_q  <= DONE_RST;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: three parameter sets,
// outputs sampled on the falling edge as {QH,QH_N,FRAME,DONE,D_READY}.
module tb_piso_shift_tx;

  logic clk;
  logic rst;

  logic [7:0] a_d, b_d, c_d;
  logic a_v, b_v, c_v;
  logic a_rdy, b_rdy, c_rdy;
  logic a_ser, b_ser, c_ser;
  logic a_qh, b_qh, c_qh;
  logic a_qhn, b_qhn, c_qhn;
  logic a_fr, b_fr, c_fr;
  logic a_dn, b_dn, c_dn;

  int total;
  int passed;
  logic [7:0] w;

  piso_shift_tx #(.WIDTH(8), .DIV(1), .GAP(0)) dut_a (
    .CLK(clk), .RST(rst), .D(a_d), .D_VALID(a_v), .D_READY(a_rdy),
    .SER_IN(a_ser), .QH(a_qh), .QH_N(a_qhn), .FRAME(a_fr), .DONE(a_dn)
  );

  piso_shift_tx #(.WIDTH(8), .DIV(3), .GAP(2)) dut_b (
    .CLK(clk), .RST(rst), .D(b_d), .D_VALID(b_v), .D_READY(b_rdy),
    .SER_IN(b_ser), .QH(b_qh), .QH_N(b_qhn), .FRAME(b_fr), .DONE(b_dn)
  );

  piso_shift_tx #(.WIDTH(8), .DIV(1), .GAP(1)) dut_c (
    .CLK(clk), .RST(rst), .D(c_d), .D_VALID(c_v), .D_READY(c_rdy),
    .SER_IN(c_ser), .QH(c_qh), .QH_N(c_qhn), .FRAME(c_fr), .DONE(c_dn)
  );

  wire [4:0] oa = {a_qh, a_qhn, a_fr, a_dn, a_rdy};
  wire [4:0] ob = {b_qh, b_qhn, b_fr, b_dn, b_rdy};
  wire [4:0] oc = {c_qh, c_qhn, c_fr, c_dn, c_rdy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ex(input logic q, input logic f,
                                    input logic d, input logic r);
    return {q, ~q, f, d, r};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b want %b (qh,qhn,frame,done,rdy)",
                tag, obs, exp);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    {a_d, b_d, c_d} = '0;
    {a_v, b_v, c_v} = '0;
    {a_ser, b_ser, c_ser} = '0;

    @(negedge clk);
    chk("rst a", oa, ex(0, 0, 0, 1));
    chk("rst b", ob, ex(0, 0, 0, 1));
    chk("rst c", oc, ex(0, 0, 0, 1));
    rst = 1'b0;

    // Single word 0xA5, DIV=1 GAP=0
    @(negedge clk);
    chk("t1 c0", oa, ex(0, 0, 0, 1));
    w = 8'hA5;
    a_d = w;
    a_v = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t1 c%0d", k), oa, ex(w[8-k], 1, 0, k == 8));
      a_v = 1'b0;
    end
    @(negedge clk);
    chk("t1 c9", oa, ex(0, 0, 1, 1));
    @(negedge clk);
    chk("t1 c10", oa, ex(0, 0, 0, 1));

    // Back-to-back 0xFF then 0x00
    a_d = 8'hFF;
    a_v = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("t2 c%0d", k), oa,
          ex(k <= 8, 1, k == 9, (k == 8) || (k == 16)));
      if (k == 1) a_d = 8'h00;
      if (k == 9) a_v = 1'b0;
    end
    @(negedge clk);
    chk("t2 c17", oa, ex(0, 0, 1, 1));

    // Busy ignore: 0x3C pulsed mid-word must be dropped
    w = 8'h5A;
    a_d = w;
    a_v = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t5 c%0d", k), oa, ex(w[8-k], 1, 0, k == 8));
      a_v = (k == 4);
      a_d = (k == 4) ? 8'h3C : 8'h00;
    end
    @(negedge clk);
    chk("t5 c9", oa, ex(0, 0, 1, 1));
    for (int k = 10; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("t5 c%0d", k), oa, ex(0, 0, 0, 1));
    end

    // Async reset at cycle 5 of a word
    w = 8'hC3;
    a_d = w;
    a_v = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t6 c%0d", k), oa, ex(w[8-k], 1, 0, 0));
      a_v = 1'b0;
    end
    #2 rst = 1'b1;
    #1 chk("t6 async", oa, ex(0, 0, 0, 1));
    @(negedge clk);
    chk("t6 hold", oa, ex(0, 0, 0, 1));
    rst = 1'b0;
    @(negedge clk);
    chk("t6 rel", oa, ex(0, 0, 0, 1));
    w = 8'h96;
    a_d = w;
    a_v = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t6n c%0d", k), oa, ex(w[8-k], 1, 0, k == 8));
      a_v = 1'b0;
    end
    @(negedge clk);
    chk("t6n c9", oa, ex(0, 0, 1, 1));

    // DIV=3 GAP=2, 0x81
    w = 8'h81;
    b_d = w;
    b_v = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("t3 c%0d", k), ob,
          ex((k <= 24) ? w[7-(k-1)/3] : 1'b0,
             k <= 24, k == 25, k >= 31));
      b_v = 1'b0;
    end

    // Cascade fill SER_IN=1, 0x00, GAP=1
    c_ser = 1'b1;
    c_d = 8'h00;
    c_v = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4 c%0d", k), oc, ex(0, 1, 0, 0));
      c_v = 1'b0;
    end
    @(negedge clk);
    chk("t4 c9", oc, ex(1, 0, 1, 0));
    @(negedge clk);
    chk("t4 c10", oc, ex(1, 0, 0, 1));
    @(negedge clk);
    chk("t4 c11", oc, ex(1, 0, 0, 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
